// File: rtl/sr_drv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sr_drv_pkg : shared types and constants for the SR bank driver
// Revision   : 1.0
// ---------------------------------------------------------------------------
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  // {s, r} excitation codes as seen by one SR flip-flop
  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RST     = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sr_excite_enc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sr_excite_enc : per-bit S/R excitation encoder; never emits the 11 code
// Revision      : 1.0
// ---------------------------------------------------------------------------
module sr_excite_enc
  import sr_drv_pkg::*;
(
  input  logic cur,
  input  logic tgt,
  input  logic frc,
  output logic s,
  output logic r
);

  logic [1:0] code;

  always_comb begin
    code = SR_HOLD;
    if (frc) begin
      code = tgt ? SR_SET : SR_RST;
    end else if (tgt && !cur) begin
      code = SR_SET;
    end else if (!tgt && cur) begin
      code = SR_RST;
    end
  end

  assign {s, r} = code;

endmodule
`default_nettype wire

// File: rtl/sr_bank_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sr_bank_driver : writes target words into an SR flip-flop bank, verifies
//                  the readback, retries with forced drive, flags stuck bits
// Revision       : 1.0
// ---------------------------------------------------------------------------
module sr_bank_driver
  import sr_drv_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_RETRY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             req_force,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] q_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_bits,
  input  logic             err_clr
);

  localparam int RETRY_W  = (clog2(MAX_RETRY + 1) < 1) ? 1 : clog2(MAX_RETRY + 1);
  localparam int SETTLE_W = (clog2(SETTLE_CYCLES + 1) < 1) ? 1 : clog2(SETTLE_CYCLES + 1);
  localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(MAX_RETRY);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST =
      SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    tgt_q, tgt_d;
  logic                frc_q, frc_d;
  logic [WIDTH-1:0]    shadow_q, shadow_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [WIDTH-1:0]    err_bits_q, err_bits_d;

  logic [WIDTH-1:0]    enc_s, enc_r;
  logic [WIDTH-1:0]    mismatch;

  for (genvar i = 0; i < WIDTH; i++) begin : g_enc
    sr_excite_enc u_enc (
      .cur (shadow_q[i]),
      .tgt (tgt_q[i]),
      .frc (frc_q),
      .s   (enc_s[i]),
      .r   (enc_r[i])
    );
  end

  assign mismatch = q_in ^ tgt_q;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    frc_d      = frc_q;
    shadow_d   = shadow_q;
    retry_d    = retry_q;
    settle_d   = settle_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_bits_d = err_bits_q;

    // A failure recorded in this same cycle is ORed on top of the cleared value
    if (err_clr) begin
      err_d      = 1'b0;
      err_bits_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          tgt_d   = req_data;
          frc_d   = req_force;
          retry_d = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        settle_d = '0;
        state_d  = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      CHECK: begin
        if (mismatch == '0) begin
          shadow_d = tgt_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (retry_q < RETRY_MAX) begin
          retry_d  = retry_q + 1'b1;
          shadow_d = q_in;
          frc_d    = 1'b1;
          state_d  = DRIVE;
        end else begin
          err_d      = 1'b1;
          err_bits_d = err_bits_d | mismatch;
          shadow_d   = q_in;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      frc_q      <= 1'b0;
      shadow_q   <= '0;
      retry_q    <= '0;
      settle_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_bits_q <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      frc_q      <= frc_d;
      shadow_q   <= shadow_d;
      retry_q    <= retry_d;
      settle_q   <= settle_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_bits_q <= err_bits_d;
    end
  end

  // Gated by state so the async reset drops the excitation without an edge
  assign s_out     = (state_q == DRIVE) ? enc_s : '0;
  assign r_out     = (state_q == DRIVE) ? enc_r : '0;
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign err_bits  = err_bits_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_bank_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sr_bank_driver : bench for sr_bank_driver with a behavioural SR bank
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_sr_bank_driver;

  localparam int WIDTH         = 8;
  localparam int SETTLE_CYCLES = 1;
  localparam int MAX_RETRY     = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic             req_force;
  logic [WIDTH-1:0] s_out;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] q_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] err_bits;
  logic             err_clr;

  logic [WIDTH-1:0] st0;
  logic [WIDTH-1:0] st1;
  logic             bank_bit [WIDTH];
  logic [WIDTH-1:0] bank_q;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] m_shadow;
  logic [WIDTH-1:0] m_bank;
  logic             m_err;
  logic [WIDTH-1:0] m_err_bits;

  always #5 clk = ~clk;

  sr_bank_driver #(
    .WIDTH         (WIDTH),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .MAX_RETRY     (MAX_RETRY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_force (req_force),
    .s_out     (s_out),
    .r_out     (r_out),
    .q_in      (q_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_bits  (err_bits),
    .err_clr   (err_clr)
  );

  // Bank of posedge SR flip-flops with async reset; 11 yields X
  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    always_ff @(posedge clk or posedge rst) begin
      if (rst) bank_bit[i] <= 1'b0;
      else begin
        case ({s_out[i], r_out[i]})
          2'b10:   bank_bit[i] <= 1'b1;
          2'b01:   bank_bit[i] <= 1'b0;
          2'b11:   bank_bit[i] <= 1'bx;
          default: bank_bit[i] <= bank_bit[i];
        endcase
      end
    end
  end

  always_comb begin
    bank_q = '0;
    for (int i = 0; i < WIDTH; i++) bank_q[i] = bank_bit[i];
  end

  assign q_in = (bank_q & ~st0) | st1;

  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      assert ((s_out & r_out) === '0) n_pass++;
      else begin
        n_fail++;
        $error("FAIL sr_illegal: s&r observed %0h required 0", s_out & r_out);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_shadow   = '0;
    m_bank     = '0;
    m_err      = 1'b0;
    m_err_bits = '0;
  endtask

  // Issues one request from an IDLE cycle and follows it to its done cycle.
  // clr_final raises err_clr exactly during the last CHECK.
  task automatic do_req(input logic [WIDTH-1:0] tgt, input logic frc, input logic clr_final);
    logic [WIDTH-1:0] es, er, q, mm;
    logic             final_chk;
    chk("idle_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_data  = tgt;
    req_force = frc;
    step();
    for (int a = 0; a <= MAX_RETRY; a++) begin
      req_valid = 1'($urandom);
      req_data  = WIDTH'($urandom);
      req_force = 1'($urandom);
      if (frc || a > 0) begin
        es = tgt;
        er = ~tgt;
      end else begin
        es = tgt & ~m_shadow;
        er = ~tgt & m_shadow;
      end
      chk("drive_s", s_out, es);
      chk("drive_r", r_out, er);
      chk("drive_busy", {busy, req_ready, done}, 3'b100);
      m_bank = (m_bank & ~er) | es;
      step();
      for (int k = 0; k < SETTLE_CYCLES; k++) begin
        chk("settle_sr", {s_out, r_out}, '0);
        chk("settle_busy", {busy, done}, 2'b10);
        step();
      end
      q  = (m_bank & ~st0) | st1;
      mm = q ^ tgt;
      final_chk = (mm == '0) || (a == MAX_RETRY);
      if (final_chk) req_valid = 1'b0;
      if (final_chk && clr_final) err_clr = 1'b1;
      chk("check_sr", {s_out, r_out}, '0);
      chk("check_done", done, 1'b0);
      step();
      err_clr = 1'b0;
      if (final_chk && clr_final) begin
        m_err      = 1'b0;
        m_err_bits = '0;
      end
      if (mm == '0) begin
        m_shadow = tgt;
        break;
      end
      m_shadow = q;
      if (a == MAX_RETRY) begin
        m_err      = 1'b1;
        m_err_bits = m_err_bits | mm;
      end
    end
    req_valid = 1'b0;
    chk("done_pulse", {done, req_ready, busy}, 3'b110);
    chk("done_err", err, m_err);
    chk("done_err_bits", err_bits, m_err_bits);
    chk("done_q_in", q_in, (m_bank & ~st0) | st1);
  endtask

  initial begin
    logic [WIDTH-1:0] t;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_data  = '0;
    req_force = 1'b0;
    err_clr   = 1'b0;
    st0       = '0;
    st1       = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_ctl", {req_ready, busy, done, err}, 4'b1000);
    chk("reset_err_bits", err_bits, '0);
    chk("reset_sr", {s_out, r_out}, '0);

    // Plain writes, repeat write (hold), forced rewrite
    do_req(8'hA5, 1'b0, 1'b0);
    do_req(8'h3C, 1'b0, 1'b0);
    do_req(8'h3C, 1'b0, 1'b0);
    do_req(8'h3C, 1'b1, 1'b0);
    step();
    chk("idle_no_done", done, 1'b0);

    // Bit 2 stuck low: retries exhausted, then shadow shows up in next write
    st0 = 8'h04;
    do_req(8'hFF, 1'b0, 1'b0);
    chk("stuck_err_bits", err_bits, 8'h04);
    do_req(8'hFF, 1'b0, 1'b0);
    st0 = '0;
    do_req(8'hFF, 1'b0, 1'b0);

    // Reset during SETTLE
    req_valid = 1'b1;
    req_data  = 8'h5A;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("rst_settle_sr", {s_out, r_out}, '0);
    chk("rst_settle_ctl", {busy, req_ready, err}, 3'b010);
    chk("rst_settle_bank", q_in, '0);
    @(posedge clk);
    #1;
    chk("rst_settle_done", done, 1'b0);
    rst = 1'b0;
    model_reset();

    // Reset during DRIVE drops excitation without waiting for an edge
    req_valid = 1'b1;
    req_data  = 8'h81;
    step();
    req_valid = 1'b0;
    chk("pre_rst_drive_s", s_out, 8'h81);
    rst = 1'b1;
    #1;
    chk("rst_drive_sr", {s_out, r_out}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_drive_done", done, 1'b0);
    model_reset();
    do_req(8'h01, 1'b0, 1'b0);

    // err_clr colliding with a new failure, then err_clr alone
    st1 = 8'h20;
    do_req(8'h00, 1'b0, 1'b0);
    chk("first_err_bits", err_bits, 8'h20);
    st1 = '0;
    st0 = 8'h02;
    do_req(8'h02, 1'b0, 1'b1);
    chk("clr_collide", {err, err_bits}, {1'b1, 8'h02});
    st0 = '0;
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    m_err      = 1'b0;
    m_err_bits = '0;
    chk("clr_alone", {err, err_bits}, 9'h000);

    // Randomised traffic with occasional stuck bits and err_clr
    for (int n = 0; n < 40; n++) begin
      t   = WIDTH'(1 << $urandom_range(WIDTH - 1));
      st0 = ($urandom_range(3) == 0) ? t : '0;
      t   = WIDTH'(1 << $urandom_range(WIDTH - 1));
      st1 = ($urandom_range(3) == 0) ? (t & ~st0) : '0;
      do_req(WIDTH'($urandom), ($urandom_range(3) == 0), ($urandom_range(4) == 0));
      if ($urandom_range(1) == 0) begin
        step();
        chk("rand_idle_done", done, 1'b0);
      end
    end
    st0 = '0;
    st1 = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
